// File: rtl/alu_src_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_src_arbiter_pkg
// Brief    : Shared sizes, state encoding and helpers for the ALU source arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package alu_src_arbiter_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    function automatic logic [SEL_W:0] popcnt16(input logic [N_REQ-1:0] v);
        logic [SEL_W:0] n;
        n = '0;
        for (int i = 0; i < N_REQ; i++) begin
            n = n + {{SEL_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_src_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick16
// Brief    : Finds the first set request bit scanning upward from a start
//            index, wrapping 15 to 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick16
    import alu_src_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_start,
    output logic             o_found,
    output logic [SEL_W-1:0] o_idx
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        logic [SEL_W-1:0] w_pos;
        o_found = 1'b0;
        o_idx   = i_start;
        w_pos   = i_start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos = i_start + SEL_W'(k);
            if (i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_src_arbiter
// Brief    : Round-robin arbiter driving the select/enable of the shared
//            16:1 ALU source mux, with valid/ready output and one-hot ack.
// Revision : 1.0 - initial release
// ============================================================================
module alu_src_arbiter
    import alu_src_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] mux_sel,
    output logic             mux_en,
    output logic             out_valid,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] ack,
    output logic [SEL_W:0]   busy_cnt
);

    arb_state_t       r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic             r_valid;
    logic [N_REQ-1:0] r_grant;
    logic [SEL_W:0]   r_busy;

    logic             w_hs;
    logic [N_REQ-1:0] w_pick_req;
    logic [SEL_W-1:0] w_pick_start;
    logic             w_found;
    logic [SEL_W-1:0] w_idx;

    assign w_hs = (r_state == GRANTED) && out_ready;

    // One picker serves both cases: a fresh pick from ptr when idle, or the
    // follow-on pick after a handshake with the departing winner masked.
    always_comb begin
        w_pick_req   = req;
        w_pick_start = r_ptr;
        if (r_state == GRANTED) begin
            w_pick_req   = req & ~r_grant;
            w_pick_start = r_sel + SEL_W'(1);
        end
    end

    rr_pick16 u_pick (
        .i_req   (w_pick_req),
        .i_start (w_pick_start),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_grant <= '0;
            r_busy  <= '0;
        end else begin
            r_busy <= popcnt16(req & ~r_grant);
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_idx;
                        r_grant <= N_REQ'(1) << w_idx;
                        r_valid <= 1'b1;
                        r_state <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (w_hs) begin
                        r_ptr <= r_sel + SEL_W'(1);
                        if (w_found) begin
                            r_sel   <= w_idx;
                            r_grant <= N_REQ'(1) << w_idx;
                        end else begin
                            r_grant <= '0;
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mux_sel   = r_sel;
    assign mux_en    = r_valid;
    assign out_valid = r_valid;
    assign grant     = r_grant;
    assign busy_cnt  = r_busy;
    // Reset in the same cycle suppresses the pulse: a dropped grant is never acked.
    assign ack       = (!rst && w_hs) ? r_grant : '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_src_arbiter
// Brief    : Scoreboard bench for alu_src_arbiter against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_src_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        out_ready;
    logic [3:0]  mux_sel;
    logic        mux_en;
    logic        out_valid;
    logic [15:0] grant;
    logic [15:0] ack;
    logic [4:0]  busy_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [3:0]  sel;
        logic        valid;
        logic [15:0] grant;
        logic [4:0]  busy;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state
    logic        m_granted;
    logic [3:0]  m_ptr;
    logic [3:0]  m_sel;
    logic        m_valid;
    logic [15:0] m_grant;
    logic [4:0]  m_busy;

    always #5 clk = ~clk;

    alu_src_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .mux_sel   (mux_sel),
        .mux_en    (mux_en),
        .out_valid (out_valid),
        .grant     (grant),
        .ack       (ack),
        .busy_cnt  (busy_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic int first_from(input logic [15:0] v, input int start);
        for (int k = 0; k < 16; k++) begin
            if (v[(start + k) % 16]) return (start + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [15:0] q, input logic rdy);
        int w;
        int cnt;
        if (r) begin
            m_granted = 0; m_ptr = 0; m_sel = 0; m_valid = 0; m_grant = 0; m_busy = 0;
        end else begin
            cnt = 0;
            for (int i = 0; i < 16; i++) if (q[i] && !m_grant[i]) cnt++;
            m_busy = 5'(cnt);
            if (!m_granted) begin
                w = first_from(q, int'(m_ptr));
                if (w >= 0) begin
                    m_sel = 4'(w); m_grant = 16'(1) << w; m_valid = 1; m_granted = 1;
                end
            end else if (rdy) begin
                m_ptr = m_sel + 4'd1;
                w = first_from(q & ~m_grant, int'(m_ptr));
                if (w >= 0) begin
                    m_sel = 4'(w); m_grant = 16'(1) << w;
                end else begin
                    m_grant = 0; m_valid = 0; m_granted = 0;
                end
            end
        end
    endtask

    // One clock: drive, check combinational ack, predict, clock, compare.
    task automatic cycle(input logic r, input logic [15:0] q, input logic rdy);
        exp_t e;
        logic [15:0] exp_ack;
        rst = r; req = q; out_ready = rdy;
        #1;
        exp_ack = (!r && m_granted && rdy) ? m_grant : 16'h0;
        chk("ack", 32'(ack), 32'(exp_ack));
        model_edge(r, q, rdy);
        sb_q.push_back('{sel: m_sel, valid: m_valid, grant: m_grant, busy: m_busy});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("mux_sel", 32'(mux_sel), 32'(e.sel));
        chk("out_valid", 32'(out_valid), 32'(e.valid));
        chk("mux_en", 32'(mux_en), 32'(e.valid));
        chk("grant", 32'(grant), 32'(e.grant));
        chk("busy_cnt", 32'(busy_cnt), 32'(e.busy));
    endtask

    initial begin
        logic [3:0] rr_exp [5];
        rr_exp = '{4'd0, 4'd4, 4'd8, 4'd0, 4'd4};
        rst = 1'b1; req = '0; out_ready = 1'b0;
        m_granted = 0; m_ptr = 0; m_sel = 0; m_valid = 0; m_grant = 0; m_busy = 0;
        @(posedge clk); #1;

        // Reset held with all requesting, then first grant goes to requester 0
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hFFFF, 1'b0);
        chk("rst_grant", 32'(grant), 32'h0);
        cycle(1'b0, 16'hFFFF, 1'b0);
        chk("first_grant", 32'(grant), 32'h0001);
        chk("first_sel", 32'(mux_sel), 32'h0);

        // Round-robin order
        cycle(1'b1, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 16'h0111, 1'b1);
            chk("rr_sel", 32'(mux_sel), 32'(rr_exp[i]));
        end

        // Backpressure then release
        cycle(1'b1, 16'h0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0020, 1'b0);
        chk("bp_sel", 32'(mux_sel), 32'd5);
        chk("bp_valid", 32'(out_valid), 32'd1);
        rst = 1'b0; req = 16'h0020; out_ready = 1'b1; #1;
        chk("bp_ack", 32'(ack), 32'h0020);
        cycle(1'b0, 16'h0020, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        chk("bp_ack_once", 32'(ack), 32'h0);

        // Pointer wrap after requester 15
        cycle(1'b1, 16'h0, 1'b0);
        cycle(1'b0, 16'h8000, 1'b0);
        chk("wrap_sel15", 32'(mux_sel), 32'd15);
        cycle(1'b0, 16'h8000, 1'b1);
        cycle(1'b0, 16'h8002, 1'b1);
        chk("wrap_sel1", 32'(mux_sel), 32'd1);
        cycle(1'b0, 16'h8002, 1'b1);
        chk("wrap_sel15b", 32'(mux_sel), 32'd15);

        // Single continuous requester alternates
        cycle(1'b1, 16'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 16'h0004, 1'b1);
            chk("single_valid", 32'(out_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Reset mid-transfer
        cycle(1'b1, 16'h0, 1'b0);
        cycle(1'b0, 16'h0080, 1'b0);
        chk("mid_sel7", 32'(mux_sel), 32'd7);
        cycle(1'b1, 16'h0080, 1'b1);
        chk("mid_grant", 32'(grant), 32'h0);
        cycle(1'b0, 16'h0081, 1'b0);
        chk("mid_sel0", 32'(mux_sel), 32'd0);

        // Random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 29) == 0),
                  16'($urandom) & 16'($urandom),
                  ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
